// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder slice: FSM state encoding,
// memory-mapped I/O addresses and the bus widths.
package mem_pkg;

   localparam int ADDR_W = 8;
   localparam int WORD_W = 16;

   localparam logic [ADDR_W-1:0] IO_LEDR  = 8'hF0;
   localparam logic [ADDR_W-1:0] IO_SW    = 8'hF1;
   localparam logic [ADDR_W-1:0] IO_TIMER = 8'hF2;

   typedef enum logic [1:0] {
      LOAD_HI = 2'd0,
      LOAD_LO = 2'd1,
      HOLD    = 2'd2,
      RUN     = 2'd3
   } state_t;

endpackage

// File: rtl/mem_responder_array.sv
// Synchronous-read word RAM, RAM_TOP+1 words deep. A read and a write to the
// same address in one cycle returns the old contents.
module mem_array
   import mem_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RAM_TOP = 8'hEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [0:RAM_TOP];

   // No reset: contents must survive a system reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/mem_responder.sv
// Boot loader + CPU memory responder: loads a byte stream into RAM, holds the
// CPU in reset, then serves RAM and MMIO. Optional MMIO timer: MMIO_TIMER_EN.
module mem_responder
   import mem_pkg::*;
#(
   parameter int                RST_HOLD = 2,
   parameter logic [ADDR_W-1:0] RAM_TOP  = 8'hEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_w_en,
   input  logic [WORD_W-1:0] cpu_w_data,
   output logic [WORD_W-1:0] cpu_r_data,
   output logic              cpu_rst_n,
   input  logic              ld_valid,
   input  logic [7:0]        ld_data,
   input  logic              ld_done,
   output logic              ld_ready,
   output logic              load_err,
   input  logic [9:0]        sw,
   output logic [9:0]        ledr,
   output logic [1:0]        fsm_state
);

   state_t            state, state_next;
   logic [ADDR_W:0]   ld_ptr;
   logic [7:0]        hi_byte;
   logic [7:0]        hold_cnt;
   logic              hi_latch, lo_accept, err_set;
   logic              run, ptr_ok, lo_write, hold_done, cpu_ram;
   logic [9:0]        sw_meta, sw_sync;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [WORD_W-1:0] ram_wdata, ram_q, io_rd, io_q;
   logic              ram_sel_q;

   assign run       = (state == RUN);
   assign ptr_ok    = (ld_ptr <= {1'b0, RAM_TOP});
   assign lo_write  = lo_accept && ptr_ok;
   assign hold_done = (hold_cnt == 8'(RST_HOLD - 1));
   assign cpu_ram   = (cpu_addr <= RAM_TOP);
   assign ld_ready  = (state == LOAD_HI) || (state == LOAD_LO);
   assign fsm_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD_HI;
      else     state <= state_next;
   end

   // ld_done outranks a same-cycle byte in both load states.
   always_comb begin
      state_next = state;
      hi_latch   = 1'b0;
      lo_accept  = 1'b0;
      err_set    = 1'b0;
      case (state)
         LOAD_HI: begin
            if (ld_done) begin
               state_next = HOLD;
            end else if (ld_valid) begin
               hi_latch   = 1'b1;
               state_next = LOAD_LO;
            end
         end
         LOAD_LO: begin
            if (ld_done) begin
               err_set    = 1'b1;
               state_next = HOLD;
            end else if (ld_valid) begin
               lo_accept  = 1'b1;
               err_set    = !ptr_ok;
               state_next = LOAD_HI;
            end
         end
         HOLD:    if (hold_done) state_next = RUN;
         RUN:     state_next = RUN;
         default: state_next = LOAD_HI;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_byte   <= '0;
         ld_ptr    <= '0;
         load_err  <= 1'b0;
         hold_cnt  <= '0;
         cpu_rst_n <= 1'b0;
         sw_meta   <= '0;
         sw_sync   <= '0;
         ledr      <= '0;
         io_q      <= '0;
         ram_sel_q <= 1'b0;
      end else begin
         if (hi_latch) hi_byte <= ld_data;
         if (lo_write) ld_ptr <= ld_ptr + 1'b1;
         if (err_set)  load_err <= 1'b1;
         hold_cnt  <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
         cpu_rst_n <= run;
         sw_meta   <= sw;
         sw_sync   <= sw_meta;
         if (run && cpu_w_en && cpu_addr == IO_LEDR) ledr <= cpu_w_data[9:0];
         ram_sel_q <= run && cpu_ram;
         io_q      <= (run && !cpu_ram) ? io_rd : '0;
      end
   end

`ifdef MMIO_TIMER_EN
   logic [WORD_W-1:0] timer;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer <= '0;
      end else if (run) begin
         timer <= (cpu_w_en && cpu_addr == IO_TIMER) ? '0 : timer + 1'b1;
      end
   end
`endif

   always_comb begin
      io_rd = '0;
      case (cpu_addr)
         IO_LEDR:  io_rd = {6'b0, ledr};
         IO_SW:    io_rd = {6'b0, sw_sync};
`ifdef MMIO_TIMER_EN
         IO_TIMER: io_rd = timer;
`endif
         default:  io_rd = '0;
      endcase
   end

   // One shared write port: the loader owns it before RUN, the CPU after.
   assign ram_we    = lo_write || (run && cpu_w_en && cpu_ram);
   assign ram_waddr = run ? cpu_addr : ld_ptr[ADDR_W-1:0];
   assign ram_wdata = run ? cpu_w_data : {hi_byte, ld_data};

   mem_array #(.RAM_TOP(RAM_TOP)) u_mem (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (cpu_addr),
      .rdata (ram_q)
   );

   assign cpu_r_data = ram_sel_q ? ram_q : io_q;

endmodule
